// File: rtl/qpsk_corr_demod.sv
// qpsk_corr_demod: coherent QPSK correlation demodulator with burst detection.
// Waits in IDLE for a sample whose magnitude exceeds the threshold, then
// correlates one sample every DECIM clocks against an external sin/cos LO
// table addressed by lo_phase. It emits one hard decision per SPS samples
// and re-arms after SYMS_PER_FRAME symbols.
// Optional feature macro: SOFT_OUT_EN adds soft_i/soft_q, the raw correlator
// sums registered with each hard decision.
module qpsk_corr_demod #(
  parameter int DATA_W         = 9,
  parameter int SPS            = 32,
  parameter int SYMS_PER_FRAME = 32,
  parameter int DECIM          = 4,
  parameter int ACC_W          = 2 * DATA_W + $clog2(SPS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic signed [DATA_W-1:0]          channel_in,
  input  logic signed [DATA_W-1:0]          lo_sin,
  input  logic signed [DATA_W-1:0]          lo_cos,
  input  logic [DATA_W-2:0]                 threshold,
  input  logic                              flush,
  output logic [$clog2(SPS)-1:0]            lo_phase,
  output logic [1:0]                        sym_out,
  output logic                              sym_valid,
  output logic [$clog2(SYMS_PER_FRAME)-1:0] sym_idx,
  output logic                              frame_start,
  output logic                              frame_done,
`ifdef SOFT_OUT_EN
  output logic signed [ACC_W-1:0]           soft_i,
  output logic signed [ACC_W-1:0]           soft_q,
`endif
  output logic                              busy
);

  localparam int PH_W  = $clog2(SPS);
  localparam int IX_W  = $clog2(SYMS_PER_FRAME);
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int EXT_W = ACC_W - 2 * DATA_W;

  localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(SPS - 1);
  localparam logic [IX_W-1:0]  LAST_SYM = IX_W'(SYMS_PER_FRAME - 1);
  localparam logic [DEC_W-1:0] LAST_DEC = DEC_W'(DECIM - 1);

  typedef enum logic {
    IDLE = 1'b0,
    ACQ  = 1'b1
  } state_t;

  state_t            state_q;
  logic [PH_W-1:0]   lo_phase_q;
  logic [DEC_W-1:0]  dec_cnt_q;
  logic [IX_W-1:0]   sym_cnt_q;
  logic [1:0]        sym_out_q;
  logic              sym_valid_q;
  logic [IX_W-1:0]   sym_idx_q;
  logic              frame_start_q;
  logic              frame_done_q;
  logic              busy_q;

  // Index 0 is the in-phase arm (lo_sin), index 1 the quadrature arm (lo_cos).
  logic signed [ACC_W-1:0]    acc_q      [2];
  logic signed [DATA_W-1:0]   lo_vec     [2];
  logic signed [2*DATA_W-1:0] prod_d     [2];
  logic signed [ACC_W-1:0]    prod_ext_d [2];
  logic signed [ACC_W-1:0]    sum_d      [2];

`ifdef SOFT_OUT_EN
  logic signed [ACC_W-1:0] soft_i_q;
  logic signed [ACC_W-1:0] soft_q_q;
`endif

  logic [DATA_W-1:0] mag_d;
  logic              detect_d;
  logic              tick_d;
  logic [1:0]        hard_d;

  assign lo_vec[0] = lo_sin;
  assign lo_vec[1] = lo_cos;

  // Per-arm product, sign extension to the accumulator width and running sum.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_arm
      assign prod_d[gi]     = channel_in * lo_vec[gi];
      assign prod_ext_d[gi] = {{EXT_W{prod_d[gi][2*DATA_W-1]}}, prod_d[gi]};
      assign sum_d[gi]      = acc_q[gi] + prod_ext_d[gi];
    end
  endgenerate

  // Magnitude in DATA_W bits so the most negative input maps to the largest value.
  assign mag_d    = channel_in[DATA_W-1] ? $unsigned(-channel_in) : $unsigned(channel_in);
  assign detect_d = ~flush & (mag_d > {1'b0, threshold});
  assign tick_d   = (dec_cnt_q == LAST_DEC);

  // Hard decision: bit1 follows the Q sign, bit0 is the inverted I sign.
  assign hard_d = {sum_d[1][ACC_W-1], ~sum_d[0][ACC_W-1]};

  // Main control: detection, sample-tick integration, symbol decisions, framing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      lo_phase_q    <= '0;
      dec_cnt_q     <= '0;
      sym_cnt_q     <= '0;
      sym_out_q     <= '0;
      sym_valid_q   <= 1'b0;
      sym_idx_q     <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      acc_q[0]      <= '0;
      acc_q[1]      <= '0;
`ifdef SOFT_OUT_EN
      soft_i_q      <= '0;
      soft_q_q      <= '0;
`endif
    end else begin
      sym_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q     <= 1'b0;
          lo_phase_q <= '0;
          // A registered frame_done means the previous frame closed on the
          // last edge; skip detection for this one clock.
          if (detect_d && !frame_done_q) begin
            state_q       <= ACQ;
            busy_q        <= 1'b1;
            acc_q[0]      <= prod_ext_d[0];
            acc_q[1]      <= prod_ext_d[1];
            lo_phase_q    <= PH_W'(1);
            dec_cnt_q     <= '0;
            sym_cnt_q     <= '0;
            frame_start_q <= 1'b1;
          end
        end
        ACQ: begin
          if (flush) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            acc_q[0]   <= '0;
            acc_q[1]   <= '0;
            lo_phase_q <= '0;
            dec_cnt_q  <= '0;
            sym_cnt_q  <= '0;
          end else begin
            dec_cnt_q <= tick_d ? '0 : dec_cnt_q + 1'b1;
            if (tick_d) begin
              if (lo_phase_q == LAST_PH) begin
                sym_out_q   <= hard_d;
                sym_valid_q <= 1'b1;
                sym_idx_q   <= sym_cnt_q;
                acc_q[0]    <= '0;
                acc_q[1]    <= '0;
                lo_phase_q  <= '0;
`ifdef SOFT_OUT_EN
                soft_i_q    <= sum_d[0];
                soft_q_q    <= sum_d[1];
`endif
                if (sym_cnt_q == LAST_SYM) begin
                  // busy stays high one more cycle; IDLE clears it.
                  frame_done_q <= 1'b1;
                  state_q      <= IDLE;
                  sym_cnt_q    <= '0;
                end else begin
                  sym_cnt_q <= sym_cnt_q + 1'b1;
                end
              end else begin
                acc_q[0]   <= sum_d[0];
                acc_q[1]   <= sum_d[1];
                lo_phase_q <= lo_phase_q + 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lo_phase    = lo_phase_q;
  assign sym_out     = sym_out_q;
  assign sym_valid   = sym_valid_q;
  assign sym_idx     = sym_idx_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
`ifdef SOFT_OUT_EN
  assign soft_i      = soft_i_q;
  assign soft_q      = soft_q_q;
`endif

endmodule
